// File: rtl/cache_read_arbiter_pkg.sv
// Shared cache definitions: arbiter state encoding, winner codes and line geometry.
package cache_read_arbiter_pkg;

  localparam int unsigned LINE_OFFSET_W = 5;
  localparam int unsigned STARVE_CNT_W  = 3;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_GNT_I = 2'd1,
    ARB_GNT_D = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    WIN_NONE = 2'd0,
    WIN_INST = 2'd1,
    WIN_DATA = 2'd2
  } arb_win_e;

endpackage

// File: rtl/cache_read_arbiter.sv
// Arbitrates ICache and DCache line reads onto a single cache-AXI read port.
// Data has priority unless inst has been passed over STARVE_LIMIT times in a row.
module cache_read_arbiter
  import cache_read_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int LINE_W       = 256,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_ren_i,
  input  logic [ADDR_W-1:0] inst_araddr_i,
  input  logic              inst_uncached_i,
  output logic              inst_rvalid_o,
  output logic [LINE_W-1:0] inst_rdata_o,
  input  logic              data_ren_i,
  input  logic [ADDR_W-1:0] data_araddr_i,
  input  logic              data_uncached_i,
  output logic              data_rvalid_o,
  output logic [LINE_W-1:0] data_rdata_o,
  input  logic              wb_busy_i,
  input  logic [ADDR_W-1:0] wb_awaddr_i,
  output logic              mem_ren_o,
  output logic [ADDR_W-1:0] mem_araddr_o,
  output logic              mem_uncached_o,
  input  logic              mem_rvalid_i,
  input  logic [LINE_W-1:0] mem_rdata_i,
  output logic [1:0]        grant_o
);

  localparam logic [STARVE_CNT_W-1:0] STARVE_MAX = STARVE_CNT_W'(STARVE_LIMIT);

  arb_state_e              state_q, state_d;
  logic [STARVE_CNT_W-1:0] starve_q, starve_d;
  logic [ADDR_W-1:0]       araddr_q, araddr_d;
  logic                    uncached_q, uncached_d;
  arb_win_e                win;
  logic                    data_hazard;
  logic                    unused_wb_offset;

  // A data read of the line currently being written back would return stale data.
  assign data_hazard = wb_busy_i &&
    (data_araddr_i[ADDR_W-1:LINE_OFFSET_W] == wb_awaddr_i[ADDR_W-1:LINE_OFFSET_W]);
  assign unused_wb_offset = ^wb_awaddr_i[LINE_OFFSET_W-1:0];

  function automatic arb_win_e pick_winner(input logic inst_req, input logic data_req,
                                           input logic hazard, input logic inst_starved);
    arb_win_e res;
    res = WIN_NONE;
    if (data_req && !hazard && !(inst_starved && inst_req)) begin
      res = WIN_DATA;
    end else if (inst_req) begin
      res = WIN_INST;
    end
    return res;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ARB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    win     = WIN_NONE;
    unique case (state_q)
      ARB_IDLE: begin
        win = pick_winner(inst_ren_i, data_ren_i, data_hazard, starve_q == STARVE_MAX);
        if (win == WIN_DATA) begin
          state_d = ARB_GNT_D;
        end else if (win == WIN_INST) begin
          state_d = ARB_GNT_I;
        end
      end
      ARB_GNT_I, ARB_GNT_D: begin
        if (mem_rvalid_i) begin
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // Grant bookkeeping only moves while idle; the latched request is frozen for the grant.
  always_comb begin
    araddr_d   = araddr_q;
    uncached_d = uncached_q;
    starve_d   = starve_q;
    if (state_q == ARB_IDLE) begin
      if (!inst_ren_i) begin
        starve_d = '0;
      end
      case (win)
        WIN_DATA: begin
          araddr_d   = data_araddr_i;
          uncached_d = data_uncached_i;
          if (inst_ren_i && (starve_q < STARVE_MAX)) begin
            starve_d = starve_q + 1'b1;
          end
        end
        WIN_INST: begin
          araddr_d   = inst_araddr_i;
          uncached_d = inst_uncached_i;
          starve_d   = '0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_q   <= '0;
      araddr_q   <= '0;
      uncached_q <= 1'b0;
    end else begin
      starve_q   <= starve_d;
      araddr_q   <= araddr_d;
      uncached_q <= uncached_d;
    end
  end

  always_comb begin
    mem_ren_o     = 1'b0;
    grant_o       = 2'b00;
    inst_rvalid_o = 1'b0;
    data_rvalid_o = 1'b0;
    inst_rdata_o  = '0;
    data_rdata_o  = '0;
    case (state_q)
      ARB_GNT_I: begin
        mem_ren_o     = 1'b1;
        grant_o       = 2'b01;
        inst_rvalid_o = mem_rvalid_i;
        inst_rdata_o  = mem_rdata_i;
      end
      ARB_GNT_D: begin
        mem_ren_o     = 1'b1;
        grant_o       = 2'b10;
        data_rvalid_o = mem_rvalid_i;
        data_rdata_o  = mem_rdata_i;
      end
      default: ;
    endcase
  end

  assign mem_araddr_o   = araddr_q;
  assign mem_uncached_o = uncached_q;

endmodule

// File: tb/tb_cache_read_arbiter.sv
// Scoreboarded bench for cache_read_arbiter: directed scenarios followed by random traffic.
module tb_cache_read_arbiter;

  localparam int ADDR_W = 32;
  localparam int LINE_W = 256;
  localparam int LIMIT  = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              inst_ren_i = 1'b0;
  logic [ADDR_W-1:0] inst_araddr_i = '0;
  logic              inst_uncached_i = 1'b0;
  logic              inst_rvalid_o;
  logic [LINE_W-1:0] inst_rdata_o;
  logic              data_ren_i = 1'b0;
  logic [ADDR_W-1:0] data_araddr_i = '0;
  logic              data_uncached_i = 1'b0;
  logic              data_rvalid_o;
  logic [LINE_W-1:0] data_rdata_o;
  logic              wb_busy_i = 1'b0;
  logic [ADDR_W-1:0] wb_awaddr_i = '0;
  logic              mem_ren_o;
  logic [ADDR_W-1:0] mem_araddr_o;
  logic              mem_uncached_o;
  logic              mem_rvalid_i = 1'b0;
  logic [LINE_W-1:0] mem_rdata_i = '0;
  logic [1:0]        grant_o;

  always #5 clk = ~clk;

  cache_read_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .inst_ren_i(inst_ren_i), .inst_araddr_i(inst_araddr_i), .inst_uncached_i(inst_uncached_i),
    .inst_rvalid_o(inst_rvalid_o), .inst_rdata_o(inst_rdata_o),
    .data_ren_i(data_ren_i), .data_araddr_i(data_araddr_i), .data_uncached_i(data_uncached_i),
    .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o),
    .wb_busy_i(wb_busy_i), .wb_awaddr_i(wb_awaddr_i),
    .mem_ren_o(mem_ren_o), .mem_araddr_o(mem_araddr_o), .mem_uncached_o(mem_uncached_o),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .grant_o(grant_o)
  );

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int                owner;   // 1 = inst, 2 = data
    logic [ADDR_W-1:0] addr;
    logic              unc;
  } grant_t;

  grant_t exp_q[$];

  // Reference model state: who owns the port, and how many times inst has been passed over.
  int m_owner  = 0;
  int m_starve = 0;
  bit m_inst_done = 1'b0;
  bit m_data_done = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_line(input string name, input logic [LINE_W-1:0] act,
                          input logic [LINE_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [LINE_W-1:0] rand_line();
    logic [LINE_W-1:0] v;
    for (int i = 0; i < LINE_W / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  always @(posedge clk) begin : model
    bit     hazard;
    grant_t g;
    if (rst) begin
      m_inst_done = 1'b0;
      m_data_done = 1'b0;
      if (m_owner != 0) begin
        if (mem_rvalid_i) begin
          if (m_owner == 1) m_inst_done = 1'b1;
          else              m_data_done = 1'b1;
          m_owner = 0;
        end
      end else begin
        hazard = wb_busy_i && (data_araddr_i[ADDR_W-1:5] == wb_awaddr_i[ADDR_W-1:5]);
        if (data_ren_i && !hazard && !(m_starve >= LIMIT && inst_ren_i)) begin
          m_owner = 2;
          g.owner = 2; g.addr = data_araddr_i; g.unc = data_uncached_i;
          exp_q.push_back(g);
          m_starve = inst_ren_i ? ((m_starve < LIMIT) ? m_starve + 1 : LIMIT) : 0;
        end else if (inst_ren_i) begin
          m_owner = 1;
          g.owner = 1; g.addr = inst_araddr_i; g.unc = inst_uncached_i;
          exp_q.push_back(g);
          m_starve = 0;
        end else begin
          m_starve = 0;
        end
      end
    end
  end

  always @(negedge clk) begin : monitor
    logic [1:0] eg;
    logic [1:0] prev_grant;
    grant_t     cur;
    if (!rst) begin
      prev_grant = 2'b00;
    end else begin
      eg = (m_owner == 1) ? 2'b01 : (m_owner == 2) ? 2'b10 : 2'b00;
      chk("mon_grant", grant_o, eg);
      chk("mon_mem_ren", mem_ren_o, eg != 2'b00);
      chk("mon_inst_rvalid", inst_rvalid_o, (m_owner == 1) && mem_rvalid_i);
      chk("mon_data_rvalid", data_rvalid_o, (m_owner == 2) && mem_rvalid_i);
      chk_line("mon_inst_rdata", inst_rdata_o, (m_owner == 1) ? mem_rdata_i : '0);
      chk_line("mon_data_rdata", data_rdata_o, (m_owner == 2) ? mem_rdata_i : '0);
      if (grant_o != 2'b00 && prev_grant == 2'b00) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL mon_unexpected_grant: got grant %0b expected none at %0t", grant_o, $time);
        end else begin
          cur = exp_q.pop_front();
          chk("mon_grant_owner", grant_o, (cur.owner == 1) ? 2'b01 : 2'b10);
          chk("mon_grant_addr", mem_araddr_o, cur.addr);
          chk("mon_grant_unc", mem_uncached_o, cur.unc);
        end
      end else if (grant_o != 2'b00) begin
        chk("mon_addr_stable", mem_araddr_o, cur.addr);
        chk("mon_unc_stable", mem_uncached_o, cur.unc);
      end
      prev_grant = grant_o;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic complete();
    mem_rdata_i  = rand_line();
    mem_rvalid_i = 1'b1;
    cyc();
    mem_rvalid_i = 1'b0;
  endtask

  task automatic assert_reset();
    rst = 1'b0;
    m_owner = 0;
    m_starve = 0;
    m_inst_done = 1'b0;
    m_data_done = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    bit allow;
    int guard;

    // Power-on reset, with a stray interface completion that must not leak out.
    assert_reset();
    mem_rvalid_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_ren", mem_ren_o, 0);
    chk("rst_grant", grant_o, 0);
    chk("rst_araddr", mem_araddr_o, 0);
    chk("rst_unc", mem_uncached_o, 0);
    chk("rst_inst_rvalid", inst_rvalid_o, 0);
    chk("rst_data_rvalid", data_rvalid_o, 0);
    mem_rvalid_i = 1'b0;
    rst = 1'b1;
    cyc();

    // Boot fetch
    inst_ren_i = 1'b1; inst_araddr_i = 32'h1FC0_0000;
    cyc();
    chk("boot_ren", mem_ren_o, 1);
    chk("boot_addr", mem_araddr_o, 32'h1FC0_0000);
    chk("boot_grant", grant_o, 2'b01);
    mem_rdata_i = rand_line(); mem_rvalid_i = 1'b1;
    #1;
    chk("boot_rvalid", inst_rvalid_o, 1);
    chk_line("boot_rdata", inst_rdata_o, mem_rdata_i);
    chk("boot_data_rvalid", data_rvalid_o, 0);
    cyc();
    mem_rvalid_i = 1'b0; inst_ren_i = 1'b0;
    chk("boot_idle", grant_o, 2'b00);
    cyc();

    // Simultaneous requests: data first, then inst after one idle cycle
    inst_ren_i = 1'b1; inst_araddr_i = 32'h1FC0_0100;
    data_ren_i = 1'b1; data_araddr_i = 32'h8000_1000;
    cyc();
    chk("both_first", grant_o, 2'b10);
    complete();
    data_ren_i = 1'b0;
    chk("both_gap", grant_o, 2'b00);
    cyc();
    chk("both_second", grant_o, 2'b01);
    chk("both_second_addr", mem_araddr_o, 32'h1FC0_0100);
    complete();
    inst_ren_i = 1'b0;
    cyc();

    // Starvation: four data grants, then inst, then the count starts over
    inst_ren_i = 1'b1; data_ren_i = 1'b1; data_araddr_i = 32'h8000_2000;
    for (int g = 0; g < 5; g++) begin
      cyc();
      chk("starve_grant", grant_o, (g < 4) ? 2'b10 : 2'b01);
      complete();
    end
    cyc();
    chk("starve_cleared", grant_o, 2'b10);
    complete();
    inst_ren_i = 1'b0; data_ren_i = 1'b0;
    cyc();

    // Write-back hazard on the same line blocks data; a different line does not
    wb_busy_i = 1'b1; wb_awaddr_i = 32'h8000_0040;
    data_araddr_i = 32'h8000_0048; data_ren_i = 1'b1;
    repeat (3) begin
      cyc();
      chk("hazard_block", grant_o, 2'b00);
    end
    wb_busy_i = 1'b0;
    cyc();
    chk("hazard_release", grant_o, 2'b10);
    complete();
    data_ren_i = 1'b0;
    cyc();
    wb_busy_i = 1'b1; data_araddr_i = 32'h8000_0060; data_ren_i = 1'b1;
    cyc();
    chk("hazard_other_line", grant_o, 2'b10);
    chk("hazard_other_addr", mem_araddr_o, 32'h8000_0060);
    complete();
    data_ren_i = 1'b0; wb_busy_i = 1'b0;
    cyc();

    // Uncached access, address churn and ren drop while granted
    data_uncached_i = 1'b1; data_araddr_i = 32'hBFAF_8000; data_ren_i = 1'b1;
    cyc();
    chk("unc_flag", mem_uncached_o, 1);
    chk("unc_addr", mem_araddr_o, 32'hBFAF_8000);
    data_araddr_i = 32'h1234_5678; data_uncached_i = 1'b0;
    cyc();
    chk("unc_addr_held", mem_araddr_o, 32'hBFAF_8000);
    chk("unc_flag_held", mem_uncached_o, 1);
    data_ren_i = 1'b0;
    cyc();
    chk("drop_keeps_grant", grant_o, 2'b10);
    complete();
    cyc();

    // Reset in the middle of a data grant
    data_ren_i = 1'b1; data_araddr_i = 32'h8000_3000;
    cyc();
    chk("mid_rst_pre", grant_o, 2'b10);
    mem_rdata_i = rand_line(); mem_rvalid_i = 1'b1;
    #1;
    assert_reset();
    #1;
    chk("mid_rst_ren", mem_ren_o, 0);
    chk("mid_rst_grant", grant_o, 0);
    chk("mid_rst_addr", mem_araddr_o, 0);
    chk("mid_rst_rvalid", data_rvalid_o, 0);
    data_ren_i = 1'b0;
    cyc();
    rst = 1'b1;
    #1;
    chk("post_rst_rvalid", data_rvalid_o, 0);
    chk("post_rst_grant", grant_o, 0);
    cyc();
    mem_rvalid_i = 1'b0;
    cyc();

    // Random traffic
    allow = 1'b1;
    guard = 0;
    for (int i = 0; i < 3000 + 400; i++) begin
      if (i >= 3000) begin
        allow = 1'b0;
        if (!inst_ren_i && !data_ren_i && m_owner == 0) break;
        guard++;
      end
      cyc();
      if (m_inst_done) inst_ren_i = 1'b0;
      else if (!inst_ren_i && allow && m_owner != 1 && $urandom_range(0, 2) == 0) begin
        inst_ren_i = 1'b1;
        inst_araddr_i = $urandom;
        inst_uncached_i = 1'($urandom_range(0, 1));
      end
      if (m_data_done) data_ren_i = 1'b0;
      else if (!data_ren_i && allow && m_owner != 2 && $urandom_range(0, 2) == 0) begin
        data_ren_i = 1'b1;
        data_araddr_i = 32'h8000_0000 + 32'($urandom_range(0, 127));
        data_uncached_i = 1'($urandom_range(0, 1));
      end
      if (m_owner == 1 && $urandom_range(0, 1) == 1) inst_araddr_i = $urandom;
      if (m_owner == 2 && $urandom_range(0, 1) == 1) data_araddr_i = $urandom;
      if (m_owner == 2 && $urandom_range(0, 7) == 0) data_ren_i = 1'b0;
      wb_busy_i    = allow ? 1'($urandom_range(0, 1)) : 1'b0;
      wb_awaddr_i  = 32'h8000_0000 + 32'($urandom_range(0, 127));
      mem_rvalid_i = ($urandom_range(0, 2) == 0);
      mem_rdata_i  = rand_line();
    end
    chk("drain_done", {inst_ren_i, data_ren_i, 1'(m_owner != 0)}, 3'b000);
    mem_rvalid_i = 1'b0;
    repeat (3) cyc();
    chk("queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cache_read_arbiter.md
CACHE_READ_ARBITER -- requirements
Module: cache_read_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width.
REQ-002 SHALL have parameter LINE_W, default 256, cache-line width.
REQ-003 SHALL have parameter STARVE_LIMIT, default 4, consecutive data grants before inst is forced.
REQ-004 SHALL have ports:
  - clk  input  1  clock; one clock, all logic on its rising edge.
  - rst  input  1  reset; asynchronous, active-low.
  - inst_ren_i  input  1  ICache read request; level, held until inst_rvalid_o.
  - inst_araddr_i  input  ADDR_W  ICache read address.
  - inst_uncached_i  input  1  ICache request is uncached.
  - inst_rvalid_o  output  1  ICache read done pulse.
  - inst_rdata_o  output  LINE_W  ICache read data.
  - data_ren_i  input  1  DCache read request; level, held until data_rvalid_o.
  - data_araddr_i  input  ADDR_W  DCache read address.
  - data_uncached_i  input  1  DCache request is uncached.
  - data_rvalid_o  output  1  DCache read done pulse.
  - data_rdata_o  output  LINE_W  DCache read data.
  - wb_busy_i  input  1  DCache line write in flight on the AXI write side.
  - wb_awaddr_i  input  ADDR_W  address of the in-flight write.
  - mem_ren_o  output  1  read request to the cache-AXI interface.
  - mem_araddr_o  output  ADDR_W  latched granted address.
  - mem_uncached_o  output  1  latched granted uncached flag.
  - mem_rvalid_i  input  1  interface read done pulse.
  - mem_rdata_i  input  LINE_W  interface read data.
  - grant_o  output  2  one-hot current owner: bit0 inst, bit1 data.

Function
REQ-005 SHALL implement FSM states IDLE, GNT_I, GNT_D.
REQ-006 In IDLE, SHALL arbitrate each cycle, with data winning when both are eligible unless the starvation count equals STARVE_LIMIT and inst_ren_i=1.
REQ-007 Data SHALL be eligible only if data_ren_i=1 and NOT (wb_busy_i=1 and data_araddr_i[ADDR_W-1:5]==wb_awaddr_i[ADDR_W-1:5]).
REQ-008 Inst SHALL be eligible whenever inst_ren_i=1; the write hazard never blocks inst.
REQ-009 On a grant, SHALL latch the winner's address and uncached flag into mem_araddr_o/mem_uncached_o and enter GNT_x on the next edge.
REQ-010 mem_ren_o SHALL be 1 exactly in GNT_I/GNT_D, giving one cycle from request to mem_ren_o.
REQ-011 In GNT_x, mem_rvalid_i=1 SHALL drive x_rvalid_o=1 in the same cycle, combinationally, and return the FSM to IDLE on the next edge.
REQ-012 The non-owner's rvalid SHALL stay 0.
REQ-013 x_rdata_o SHALL pass mem_rdata_i through when x is the owner, and be 0 otherwise.
REQ-014 After every completed grant the FSM SHALL spend at least one IDLE cycle, so a requester must drop ren the cycle after rvalid.
REQ-015 The latched address/flag SHALL be stable for the whole grant, and SHALL ignore changes on *_araddr_i.
REQ-016 A requester dropping ren mid-grant SHALL NOT release the grant; only mem_rvalid_i ends a grant.
REQ-017 mem_rvalid_i in IDLE SHALL be ignored, with no rvalid output.
REQ-018 The starvation counter SHALL be 3 bits, saturating at STARVE_LIMIT.
REQ-019 The starvation counter SHALL increment on each data grant issued while inst_ren_i=1.
REQ-020 The starvation counter SHALL clear on an inst grant, or on any IDLE cycle with inst_ren_i=0.
REQ-021 grant_o SHALL be 2'b01 in GNT_I, 2'b10 in GNT_D, and 2'b00 in IDLE.

Reset
REQ-022 On rst=0, asynchronously: FSM=IDLE, starvation counter=0, mem_araddr_o=0, mem_uncached_o=0.
REQ-023 On rst=0, asynchronously, all *_rvalid_o and mem_ren_o SHALL be 0.
REQ-024 A reset mid-grant SHALL abandon the transfer; a later mem_rvalid_i SHALL be ignored per REQ-017.

Structure
REQ-025 State encodings and the line-offset width (5) SHALL live in the shared cache defines package.
REQ-026 The block SHALL be a single module with no sub-modules; the eligibility/priority logic may be a combinational function.

Verification
REQ-027 Bench SHALL cover: inst_ren_i=1, addr 0x1FC0_0000 -> mem_ren_o=1 next cycle, mem_araddr_o=0x1FC0_0000, grant_o=01; mem_rvalid_i -> inst_rvalid_o=1 same cycle.
REQ-028 Bench SHALL cover: inst and data both requesting in the same cycle -> grant_o=10 first; inst granted after the data rvalid plus one IDLE cycle.
REQ-029 Bench SHALL cover: data held continuously with inst waiting -> after 4 data grants the 5th grant is inst, and the counter returns to 0.
REQ-030 Bench SHALL cover: wb_busy_i=1, wb_awaddr_i=0x8000_0040, data read 0x8000_0048 -> no data grant until wb_busy_i=0; data read 0x8000_0060 -> granted immediately.
REQ-031 Bench SHALL cover: data_uncached_i=1, addr 0xBFAF_8000 -> mem_uncached_o=1; address changed mid-grant -> mem_araddr_o unchanged.
REQ-032 Bench SHALL cover: rst pulsed low in GNT_D -> outputs 0 immediately; a subsequent mem_rvalid_i produces no data_rvalid_o.
